// File: rtl/csr_pkg.sv
// ------------------------------------------------------------------
// csr_pkg: shared op encodings, exception codes and queue entry type
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package csr_pkg;

  localparam int CSR_DATA_W = 32;
  localparam int CSR_PREG_W = 7;
  localparam int CSR_ROB_W  = 6;
  localparam int CSR_NUM_W  = 14;

  localparam logic [1:0] CSR_OP_RD   = 2'd0;
  localparam logic [1:0] CSR_OP_WR   = 2'd1;
  localparam logic [1:0] CSR_OP_XCHG = 2'd2;

  localparam logic [6:0] EXC_NONE = 7'h00;
  localparam logic [6:0] EXC_INE  = 7'h0D;
  localparam logic [6:0] EXC_PPI  = 7'h0E;

  typedef struct packed {
    logic [1:0]            op;
    logic [CSR_NUM_W-1:0]  csr;
    logic                  rdable;
    logic [CSR_PREG_W-1:0] rd;
    logic [CSR_DATA_W-1:0] rj;
    logic [CSR_DATA_W-1:0] rk;
    logic [CSR_ROB_W-1:0]  robptr;
    logic                  exc;
  } csr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } csr_state_e;

  // New CSR value; rj acts as a per-bit select between rk and the old value for xchg.
  function automatic logic [CSR_DATA_W-1:0] csr_merge(
    input logic [1:0]            op,
    input logic [CSR_DATA_W-1:0] old_val,
    input logic [CSR_DATA_W-1:0] rj,
    input logic [CSR_DATA_W-1:0] rk
  );
    case (op)
      CSR_OP_WR:   csr_merge = rk;
      CSR_OP_XCHG: csr_merge = (rk & rj) | (old_val & ~rj);
      default:     csr_merge = old_val;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_queue_fifo.sv
// ------------------------------------------------------------------
// csr_queue_fifo: circular buffer with count, same-cycle push/pop, flush
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module csr_queue_fifo #(
  parameter int DEPTH = 4,
  parameter type T    = logic
) (
  input  logic Clk,
  input  logic Rest,
  input  logic Flush,
  input  logic Push,
  input  T     PushData,
  input  logic Pop,
  output T     HeadData,
  output logic Full,
  output logic Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign Full      = (r_count == CNT_W'(DEPTH));
  assign Empty     = (r_count == '0);
  assign w_do_push = Push & ~Full;
  assign w_do_pop  = Pop & ~Empty;
  assign HeadData  = r_mem[r_head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Rest || Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_W'(1);
      if (w_do_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_do_push && !Flush) r_mem[r_tail] <= PushData;
  end

endmodule

`default_nettype wire

// File: rtl/csr_retire_queue.sv
// ------------------------------------------------------------------
// csr_retire_queue: privilege-checked CSR queue with in-order retire RMW
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module csr_retire_queue
  import csr_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         DATA_W   = CSR_DATA_W,
  parameter int         PREG_W   = CSR_PREG_W,
  parameter int         ROB_W    = CSR_ROB_W,
  parameter int         CSR_W    = CSR_NUM_W,
  parameter logic [6:0] PPI_CODE = EXC_PPI
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              Stop,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        InOp,
  input  logic [CSR_W-1:0]  InCsrNum,
  input  logic              InRdAble,
  input  logic [PREG_W-1:0] InRdAddr,
  input  logic [DATA_W-1:0] InRjData,
  input  logic [DATA_W-1:0] InRdData,
  input  logic [ROB_W-1:0]  InRobPtr,
  input  logic [1:0]        InPlv,
  output logic              RobRdyValid,
  output logic [ROB_W-1:0]  RobRdyPtr,
  output logic              RobRdyExc,
  output logic [6:0]        RobRdyCode,
  input  logic              RetireValid,
  input  logic [ROB_W-1:0]  RetirePtr,
  output logic              RetireAck,
  output logic              CsrReAble,
  output logic [CSR_W-1:0]  CsrReAddr,
  input  logic [DATA_W-1:0] CsrReData,
  output logic              CsrWeAble,
  output logic [CSR_W-1:0]  CsrWeAddr,
  output logic [DATA_W-1:0] CsrWeData,
  output logic              WbAble,
  output logic [PREG_W-1:0] WbAddr,
  output logic [DATA_W-1:0] WbData,
  output logic              Busy
);

  csr_entry_t       w_in;
  csr_entry_t       w_head;
  csr_entry_t       r_cur;
  csr_state_e       r_state;
  csr_state_e       w_next;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_ack;
  logic             w_live;
  logic [DATA_W-1:0] r_old;
  logic [DATA_W-1:0] r_new;
  logic             r_rdy_valid;
  logic [ROB_W-1:0] r_rdy_ptr;
  logic             r_rdy_exc;

  // Op 3 is folded into RD at enqueue so the FSM never sees it.
  assign w_in.op     = (InOp == 2'd3) ? CSR_OP_RD : InOp;
  assign w_in.csr    = InCsrNum;
  assign w_in.rdable = InRdAble;
  assign w_in.rd     = InRdAddr;
  assign w_in.rj     = InRjData;
  assign w_in.rk     = InRdData;
  assign w_in.robptr = InRobPtr;
  assign w_in.exc    = (InPlv != 2'd0);

  assign w_live    = ~Stop & ~Rest;
  assign InReady   = ~w_full;
  assign w_push    = InValid & ~w_full & ~Stop & ~Flush;
  assign w_ack     = RetireValid & (r_state == ST_IDLE) & ~w_empty
                   & (RetirePtr == w_head.robptr) & w_live;
  assign RetireAck = w_ack;
  assign Busy      = (r_state != ST_IDLE) | ~w_empty;

  assign RobRdyValid = r_rdy_valid & w_live & ~Flush;
  assign RobRdyPtr   = r_rdy_ptr;
  assign RobRdyExc   = r_rdy_exc;
  assign RobRdyCode  = r_rdy_exc ? PPI_CODE : 7'h00;

  csr_queue_fifo #(
    .DEPTH (DEPTH),
    .T     (csr_entry_t)
  ) u_fifo (
    .Clk      (Clk),
    .Rest     (Rest),
    .Flush    (Flush & ~Stop),
    .Push     (w_push),
    .PushData (w_in),
    .Pop      (w_ack),
    .HeadData (w_head),
    .Full     (w_full),
    .Empty    (w_empty)
  );

  always_ff @(posedge Clk) begin
    if (Rest) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_old       <= '0;
      r_new       <= '0;
      r_rdy_valid <= 1'b0;
      r_rdy_ptr   <= '0;
      r_rdy_exc   <= 1'b0;
    end else if (!Stop) begin
      r_state     <= w_next;
      r_rdy_valid <= w_push;
      if (w_push) begin
        r_rdy_ptr <= InRobPtr;
        r_rdy_exc <= w_in.exc;
      end
      if (w_ack) r_cur <= w_head;
      if (r_state == ST_READ) begin
        r_old <= CsrReData;
        r_new <= csr_merge(r_cur.op, CsrReData, r_cur.rj, r_cur.rk);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    CsrReAble = 1'b0;
    CsrReAddr = '0;
    CsrWeAble = 1'b0;
    CsrWeAddr = '0;
    CsrWeData = '0;
    WbAble    = 1'b0;
    WbAddr    = '0;
    WbData    = '0;
    case (r_state)
      ST_IDLE: begin
        // Excepting entries are popped here and never touch the CSR file.
        if (w_ack && !w_head.exc) w_next = ST_READ;
      end
      ST_READ: begin
        CsrReAble = w_live;
        CsrReAddr = r_cur.csr;
        w_next    = ST_WRITE;
      end
      ST_WRITE: begin
        CsrWeAble = w_live & ((r_cur.op == CSR_OP_WR) | (r_cur.op == CSR_OP_XCHG));
        CsrWeAddr = r_cur.csr;
        CsrWeData = r_new;
        WbAble    = w_live & r_cur.rdable;
        WbAddr    = r_cur.rd;
        WbData    = r_old;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
